// File: rtl/dpram_copy_pkg.sv
// Shared definitions for the dual-port RAM copy engine: default widths,
// FSM state encoding and copy direction.
package dpram_copy_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 6;

    // Controller states; CHECK validates the latched request for one cycle.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Copy direction; BWD walks from the top of the block down so an
    // overlapping destination above the source never clobbers unread words.
    typedef enum logic {
        FWD = 1'b0,
        BWD = 1'b1
    } dir_t;

endpackage

// File: rtl/dpram_copy_pipe.sv
// Read-to-write alignment pipe: delays the "read issued" flag and the
// destination address by RD_LAT cycles so the write lands on the cycle the
// RAM presents the matching read data.
module dpram_copy_pipe #(
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              vld_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [ADDR_W-1:0] addr_q [RD_LAT];

    // Shift register; reset clears every stage so an aborted copy stops writing at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= vld_i;
            addr_q[0] <= addr_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign vld_o  = vld_q[RD_LAT-1];
    assign addr_o = addr_q[RD_LAT-1];

endmodule

// File: rtl/dpram_copy_engine.sv
// Block copy engine for a single-clock true dual-port RAM.
// Reads the source block on port A and writes the destination on port B,
// one word per cycle, choosing direction so overlapping copies behave
// like memmove. RD_LAT (1..3) must match the RAM read latency.
// Optional feature macro: DPRAM_COPY_CHECKSUM_EN adds a checksum output
// holding the modular sum of all words written by the last copy.
module dpram_copy_engine
    import dpram_copy_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] addr_a,
    output logic              we_a,
    input  logic [DATA_W-1:0] q_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              we_b,
    output logic [DATA_W-1:0] data_b
`ifdef DPRAM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    // Range checks are done two bits wider than an address so base+len
    // can represent DEPTH and beyond without wrapping.
    localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(2**ADDR_W);
    localparam logic [ADDR_W+1:0] ONE_W   = (ADDR_W+2)'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LAT_C   = (ADDR_W+1)'(RD_LAT);

    state_t            state_q, state_d;
    dir_t              dir_q, dir_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic [ADDR_W+1:0] src_end;
    logic [ADDR_W+1:0] dst_end;
    logic              range_err;
    logic              overlap_bwd;
    logic              rd_issue;

    assign src_end     = {2'b00, src_q} + {1'b0, len_q};
    assign dst_end     = {2'b00, dst_q} + {1'b0, len_q};
    assign range_err   = (src_end > DEPTH_W) || (dst_end > DEPTH_W);
    assign overlap_bwd = (dst_q > src_q) && ({2'b00, dst_q} < src_end);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dir_q     <= FWD;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            err_q     <= err_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic: request latch, validation, read sequencing and drain.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        err_d     = err_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = len;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (range_err) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (len_q == '0) begin
                    state_d = FIN;
                end else begin
                    cnt_d   = len_q;
                    state_d = RUN;
                    if (overlap_bwd) begin
                        dir_d     = BWD;
                        rd_addr_d = ADDR_W'(src_end - ONE_W);
                        wr_addr_d = ADDR_W'(dst_end - ONE_W);
                    end else begin
                        dir_d     = FWD;
                        rd_addr_d = src_q;
                        wr_addr_d = dst_q;
                    end
                end
            end
            RUN: begin
                if (cnt_q == ONE_C) begin
                    cnt_d   = LAT_C;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                    if (dir_q == BWD) begin
                        rd_addr_d = rd_addr_q - ONE_A;
                        wr_addr_d = wr_addr_q - ONE_A;
                    end else begin
                        rd_addr_d = rd_addr_q + ONE_A;
                        wr_addr_d = wr_addr_q + ONE_A;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == ONE_C) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_issue = (state_q == RUN);

    dpram_copy_pipe #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (rd_issue),
        .addr_i (wr_addr_q),
        .vld_o  (we_b),
        .addr_o (addr_b)
    );

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FIN);
    assign err    = (state_q == FIN) && err_q;
    assign addr_a = rd_addr_q;
    assign we_a   = 1'b0;
    // Gate write data so the port reads zero whenever nothing is written.
    assign data_b = we_b ? q_a : '0;

`ifdef DPRAM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    // Checksum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    // Clear at validation, then accumulate every written word.
    always_comb begin
        checksum_d = checksum_q;
        if (state_q == CHECK) begin
            checksum_d = '0;
        end else if (we_b) begin
            checksum_d = checksum_q + data_b;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_dpram_copy_engine.sv
// Self-checking bench for dpram_copy_engine with a behavioural RAM and a
// memmove/timing model. Define DPRAM_COPY_CHECKSUM_EN to cover the checksum.
module tb_dpram_copy_engine;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int L     = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, err, we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] q_a, data_b;
`ifdef DPRAM_COPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    always #5 clk = ~clk;

    dpram_copy_engine #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(L)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .addr_a   (addr_a),
        .we_a     (we_a),
        .q_a      (q_a),
        .addr_b   (addr_b),
        .we_b     (we_b),
        .data_b   (data_b)
`ifdef DPRAM_COPY_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    // Behavioural dual-port RAM with L-cycle read latency and a backdoor load port.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q_pipe [L];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    always @(posedge clk) begin
        q_pipe[0] <= mem[addr_a];
        for (int i = 1; i < L; i++) q_pipe[i] <= q_pipe[i-1];
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (we_b) mem[addr_b] <= data_b;
    end
    assign q_a = q_pipe[L-1];

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of the current request.
    bit            op_active = 1'b0;
    int            t0, m_src, m_dst, m_len, done_r, m_sum;
    bit            m_err, m_bwd;
    logic [DW-1:0] snap [DEPTH];
    int            done_seen, err_seen, wr_count;
    int            rd_seq [DEPTH];

    // Cycle-by-cycle compare against the model schedule.
    int c_r, c_k, c_off;
    bit c_ok;
    initial forever begin
        @(negedge clk);
        chk("we_a", we_a, 0);
        if (op_active) begin
            c_r  = cyc - t0;
            c_ok = !m_err && (m_len > 0);
            chk("busy", busy, (c_r >= 1 && c_r <= done_r) ? 1 : 0);
            chk("done", done, (c_r == done_r) ? 1 : 0);
            chk("err", err, (c_r == done_r && m_err) ? 1 : 0);
            if (c_ok && c_r >= 2 && c_r <= m_len + 1) begin
                c_k = c_r - 2;
                chk("addr_a", addr_a, m_bwd ? (m_src + m_len - 1 - c_k) : (m_src + c_k));
                rd_seq[c_k] = addr_a;
            end
            if (c_ok && c_r >= 2 + L && c_r <= m_len + 1 + L) begin
                c_k   = c_r - 2 - L;
                c_off = m_bwd ? (m_len - 1 - c_k) : c_k;
                chk("we_b", we_b, 1);
                chk("addr_b", addr_b, m_dst + c_off);
                chk("data_b", data_b, snap[m_src + c_off]);
            end else begin
                chk("we_b_idle", we_b, 0);
            end
            if (we_b) wr_count++;
            if (err) err_seen = 1;
            if (done) begin
                done_seen = c_r;
`ifdef DPRAM_COPY_CHECKSUM_EN
                chk("checksum", checksum, c_ok ? (m_sum & 255) : 0);
`endif
            end
            if (c_r >= done_r) op_active = 1'b0;
        end else begin
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_we_b", we_b, 0);
        end
    end

    task automatic poke(input int a, input int v);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = AW'(a); bd_data = DW'(v);
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            bd_we = 1'b1; bd_addr = AW'(i); bd_data = DW'(i);
        end
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // One copy request; ss = cycle of an extra start pulse, ra = cycle of reset.
    task automatic do_copy(input int s, input int d, input int n, input int ss, input int ra);
        int            budget, nw, off, diffs;
        bit            aborted;
        logic [DW-1:0] e_mem [DEPTH];
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) snap[i] = mem[i];
        m_src = s; m_dst = d; m_len = n;
        m_err  = (s + n > DEPTH) || (d + n > DEPTH);
        m_bwd  = (d > s) && (d < s + n);
        done_r = (m_err || n == 0) ? 2 : n + 2 + L;
        m_sum  = 0;
        if (!m_err) for (int k = 0; k < n; k++) m_sum += snap[s + k];
        done_seen = -1; err_seen = 0; wr_count = 0;
        src_addr = AW'(s); dst_addr = AW'(d); len = (AW+1)'(n);
        start = 1'b1; t0 = cyc; op_active = 1'b1;
        budget = 0; aborted = 1'b0;
        while (op_active && budget < 300) begin
            if (ra != 0 && cyc - t0 == ra - 1) begin
                @(posedge clk);
                #1;
                rst_n = 1'b0; op_active = 1'b0; aborted = 1'b1;
                #1;
                chk("rst_we_b", we_b, 0);
                chk("rst_busy", busy, 0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
                budget++;
                start = (ss != 0 && cyc - t0 == ss);
                if (start) begin
                    src_addr = '0; dst_addr = 6'd1; len = 7'd1;
                end
            end
        end
        start = 1'b0;
        chk("timeout", (budget < 300) ? 1 : 0, 1);
        for (int i = 0; i < DEPTH; i++) e_mem[i] = snap[i];
        nw = m_err ? 0 : (aborted ? ((ra - 2 - L > 0) ? ra - 2 - L : 0) : n);
        for (int k = 0; k < nw; k++) begin
            off = m_bwd ? (n - 1 - k) : k;
            e_mem[d + off] = snap[s + off];
        end
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== e_mem[i]) diffs++;
        chk("mem_diffs", diffs, 0);
        $display("copy src=%0d dst=%0d len=%0d done_cycle=%0d err=%0d writes=%0d", s, d, n, done_seen, err_seen, wr_count);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state_busy", busy, 0);
        chk("rst_state_done", done, 0);
        chk("rst_state_err", err, 0);
        chk("rst_state_we_b", we_b, 0);
        chk("rst_state_addr_a", addr_a, 0);
        chk("rst_state_addr_b", addr_b, 0);
        chk("rst_state_data_b", data_b, 0);
        rst_n = 1'b1;

        // Forward, disjoint
        load_ramp();
        do_copy(0, 32, 8, 0, 0);
        chk("fwd_done_cycle", done_seen, 11);
        chk("fwd_mem32", mem[32], 0);
        chk("fwd_mem39", mem[39], 7);
        chk("fwd_src7", mem[7], 7);

        // Overlap, destination above source: backward
        load_ramp();
        do_copy(4, 6, 8, 0, 0);
        chk("bwd_first_rd", rd_seq[0], 11);
        chk("bwd_last_rd", rd_seq[7], 4);
        chk("bwd_mem6", mem[6], 4);
        chk("bwd_mem13", mem[13], 11);
        chk("bwd_mem5", mem[5], 5);

        // Overlap, destination below source: forward
        load_ramp();
        do_copy(6, 4, 8, 0, 0);
        chk("ovf_first_rd", rd_seq[0], 6);
        chk("ovf_mem4", mem[4], 6);
        chk("ovf_mem11", mem[11], 13);

        // Out of range and zero length
        do_copy(60, 0, 8, 0, 0);
        chk("err_done_cycle", done_seen, 2);
        chk("err_flag", err_seen, 1);
        chk("err_writes", wr_count, 0);
        do_copy(10, 20, 0, 0, 0);
        chk("zero_done_cycle", done_seen, 2);
        chk("zero_err", err_seen, 0);
        chk("zero_writes", wr_count, 0);

        // Start during RUN is ignored
        load_ramp();
        do_copy(0, 40, 8, 4, 0);
        chk("busy_start_done", done_seen, 11);
        chk("busy_start_mem47", mem[47], 7);
        chk("busy_start_mem1", mem[1], 1);

        // Reset mid-copy, then a normal copy
        do_copy(0, 30, 20, 0, 5);
        chk("abort_mem31", mem[31], 1);
        chk("abort_mem32", mem[32], 32);
        do_copy(1, 60, 3, 0, 0);
        chk("post_rst_done", done_seen, 6);
        chk("post_rst_mem62", mem[62], 3);

        // src == dst and range boundaries
        do_copy(8, 8, 4, 0, 0);
        chk("same_writes", wr_count, 4);
        chk("same_mem8", mem[8], 8);
        do_copy(0, 56, 8, 0, 0);
        chk("edge_ok_err", err_seen, 0);
        chk("edge_ok_mem63", mem[63], 7);
        do_copy(57, 0, 8, 0, 0);
        chk("edge_bad_err", err_seen, 1);
        do_copy(0, 0, 64, 0, 0);
        chk("full_done", done_seen, 67);
        chk("full_writes", wr_count, 64);

`ifdef DPRAM_COPY_CHECKSUM_EN
        poke(40, 1);
        poke(41, 2);
        poke(42, 3);
        poke(43, 250);
        do_copy(40, 50, 4, 0, 0);
        chk("csum_wrap", checksum, 0);
        do_copy(40, 50, 3, 0, 0);
        chk("csum_six", checksum, 6);
        do_copy(10, 20, 0, 0, 0);
        chk("csum_zero_len", checksum, 0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dpram_copy_engine.md
Name: dpram_copy_engine

Overview:
- Initiator that drives both ports of a single-clock true dual-port RAM (64 x 8).
- Copies a block of `len` words from `src_addr` to `dst_addr`: reads on port A, writes on port B, one word per cycle.
- Overlapping ranges are handled with memmove semantics.
- Sits between the control logic (start/done handshake) and the dual-port RAM.

Parameters:
- DATA_W, 8, RAM word width.
- ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W.
- RD_LAT, 1, RAM read latency in cycles from address to q_a; legal values 1..3.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  copy request; sampled only in IDLE.
- src_addr  in  ADDR_W  source base address.
- dst_addr  in  ADDR_W  destination base address.
- len  in  ADDR_W+1  word count, 0..DEPTH.
- busy  out  1  copy in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done; request rejected.
- addr_a  out  ADDR_W  RAM port A read address.
- we_a  out  1  tied 0; port A is read-only.
- q_a  in  DATA_W  RAM port A read data.
- addr_b  out  ADDR_W  RAM port B write address.
- we_b  out  1  RAM port B write enable.
- data_b  out  DATA_W  RAM port B write data.

Behaviour:
- Reset (asynchronous, immediate): busy, done, err, we_b = 0; addr_a, addr_b, data_b = 0; FSM = IDLE. Reset mid-copy aborts with no further writes. Partial copy is not undone.
- FSM states: IDLE, CHECK, RUN, DRAIN, FIN.
- IDLE: start=1 latches src, dst, len; go to CHECK. start in any other state is ignored.
- CHECK (1 cycle):
  - Error: src+len > DEPTH or dst+len > DEPTH (computed ADDR_W+2 wide). Go to FIN with err.
  - len=0: go to FIN, no RAM activity.
  - Direction: backward if dst > src and dst < src+len; otherwise forward.
  - Go to RUN.
- RUN: one read address per cycle for `len` cycles.
  - Forward: src, src+1, ...
  - Backward: src+len-1 downward.
  - Go to DRAIN after the last read is issued.
- Write pipeline: read issue and target address are delayed by an RD_LAT-deep shift register.
  - we_b=1, addr_b = matching dst address, data_b = q_a, exactly RD_LAT cycles after each read.
  - Writes begin during RUN and overlap it.
- DRAIN: wait until the pipeline is empty (RD_LAT cycles after the last read), then go to FIN.
- FIN: done=1 for one cycle, err=1 if rejected; return to IDLE.
- busy = 1 in CHECK, RUN, DRAIN and FIN; 0 in IDLE.
- Latency, with start sampled at cycle 0:
  - Reads in cycles 2..len+1.
  - Writes in cycles 2+RD_LAT..len+1+RD_LAT.
  - done at cycle len+2+RD_LAT.
  - len=0 or error: done at cycle 2.
- src == dst: copy executes normally (rewrites identical data).
- Ordering guarantee: each source word is read before any write to that address, in both directions.

Optional Feature:
- Macro: DPRAM_COPY_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [DATA_W-1:0], the modular sum of all words written in the last copy.
  - Cleared in CHECK, accumulated on every we_b cycle.
  - Valid from the done pulse and held until the next accepted start.
  - Reset value 0; 0 after len=0 or an error.
- When undefined: the port and the adder are absent; behaviour is otherwise identical.

Decomposition:
- Package dpram_copy_pkg:
  - FSM state enum.
  - Default widths DATA_W/ADDR_W.
  - Direction enum {FWD, BWD}.
- One sub-module: dpram_copy_pipe, the RD_LAT-deep valid/address shift register producing we_b/addr_b.
- RAM model instantiated only in the bench.

Test Plan:
- Forward copy: RAM[i]=i; start src=0, dst=32, len=8 → RAM[32..39]=0..7; done at cycle 11 (RD_LAT=1); src region unchanged.
- Overlap backward: RAM[i]=i; src=4, dst=6, len=8 → RAM[6..13]=4..11, RAM[4..5]=4,5; addr_a sequence 11,10,...,4.
- Overlap forward: src=6, dst=4, len=8 → RAM[4..11]=6..13; forward addr order.
- Error and zero length:
  - src=60, len=8 → err=1 with done at cycle 2, we_b never asserted.
  - len=0 → done at cycle 2, err=0, no writes.
- Start during busy and reset mid-copy:
  - Second start during RUN is ignored.
  - rst_n low at cycle 5 of a len=20 copy → we_b=0 immediately, busy=0, next start accepted normally.
- With DPRAM_COPY_CHECKSUM_EN: copy of words 1,2,3,250 → checksum=0x00 (256 mod 256); copy of 1,2,3 → 0x06.
